note_sequencer: RTL

- Records up to DEPTH key presses (note + octave) from the keyboard-conversion stage into an internal buffer.
- On a playback request, replays them as a timed sequence of tone frequencies.
- Drives the 32-bit frequency word consumed by the audio tone-generation block; sits between keyboard decode and audio output.
- In IDLE, passes the currently held key through as a live tone.

---
 rtl/note_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/note_sequencer.sv
`timescale 1ns/1ps
// Records key presses (note + octave) and replays them as timed tone frequencies.
// Define NOTE_SEQUENCER_LOOP_EN to repeat playback until stopped by a second request.
module note_sequencer #(
    parameter int DEPTH      = 16,
    parameter int NOTE_TICKS = 12500000,
    parameter int GAP_TICKS  = 1250000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  note,
    input  logic [1:0]  octave,
    input  logic        load_n,
    input  logic        playback,
    input  logic        clear,
    output logic [31:0] freq_out,
    output logic [3:0]  note_counter,
    output logic        playing,
    output logic        full
);

    localparam int IW    = $clog2(DEPTH);
    localparam int CW    = IW + 1;
    localparam int MAX_T = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int TW    = ($clog2(MAX_T) > 0) ? $clog2(MAX_T) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY_NOTE = 2'd1,
        PLAY_GAP  = 2'd2
    } state_t;

    // Entry layout is {octave, note}; rests (notes 12-15) map to silence.
    function automatic logic [31:0] tone(input logic [5:0] entry);
        logic [11:0] base;
        case (entry[3:0])
            4'd0:    base = 12'd262;
            4'd1:    base = 12'd277;
            4'd2:    base = 12'd294;
            4'd3:    base = 12'd311;
            4'd4:    base = 12'd330;
            4'd5:    base = 12'd349;
            4'd6:    base = 12'd370;
            4'd7:    base = 12'd392;
            4'd8:    base = 12'd415;
            4'd9:    base = 12'd440;
            4'd10:   base = 12'd466;
            4'd11:   base = 12'd494;
            default: base = 12'd0;
        endcase
        return 32'(base) << entry[5:4];
    endfunction

    state_t          state_q, state_nxt;
    logic [CW-1:0]   count_q, count_nxt;
    logic [IW-1:0]   idx_q, idx_nxt, idx_inc;
    logic [TW-1:0]   timer_q, timer_nxt;
    logic [31:0]     freq_nxt;
    logic            load_n_d, playback_d;
    logic            load_edge, play_edge, last_entry, mem_we;
    logic [5:0]      mem [DEPTH];

    assign load_edge  = ~load_n & load_n_d;
    assign play_edge  = playback & ~playback_d;
    assign idx_inc    = idx_q + IW'(1);
    assign last_entry = (CW'(idx_q) == count_q - CW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
            freq_out   <= '0;
            load_n_d   <= 1'b1;
            playback_d <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q    <= state_nxt;
            count_q    <= count_nxt;
            idx_q      <= idx_nxt;
            timer_q    <= timer_nxt;
            freq_out   <= freq_nxt;
            load_n_d   <= load_n;
            playback_d <= playback;
        end
    end

    // NOTE: the buffer is deliberately left out of reset; count alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (mem_we) mem[count_q[IW-1:0]] <= {octave, note};
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt = state_q;
        count_nxt = count_q;
        idx_nxt   = idx_q;
        timer_nxt = timer_q;
        freq_nxt  = freq_out;
        mem_we    = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            count_nxt = '0;
            idx_nxt   = '0;
            timer_nxt = '0;
            freq_nxt  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    freq_nxt = load_n ? 32'd0 : tone({octave, note});
                    if (play_edge && count_q != '0) begin
                        state_nxt = PLAY_NOTE;
                        idx_nxt   = '0;
                        timer_nxt = '0;
                        freq_nxt  = tone(mem[0]);
                    end else if (load_edge && count_q != CW'(DEPTH)) begin
                        mem_we    = 1'b1;
                        count_nxt = count_q + CW'(1);
                    end
                end
                PLAY_NOTE: begin
                    timer_nxt = timer_q + TW'(1);
                    if (timer_q == TW'(NOTE_TICKS - 1)) begin
                        state_nxt = PLAY_GAP;
                        timer_nxt = '0;
                        freq_nxt  = '0;
                    end
                end
                PLAY_GAP: begin
                    timer_nxt = timer_q + TW'(1);
                    if (timer_q == TW'(GAP_TICKS - 1)) begin
                        timer_nxt = '0;
                        if (!last_entry) begin
                            idx_nxt   = idx_inc;
                            state_nxt = PLAY_NOTE;
                            freq_nxt  = tone(mem[idx_inc]);
                        end else begin
`ifdef NOTE_SEQUENCER_LOOP_EN
                            idx_nxt   = '0;
                            state_nxt = PLAY_NOTE;
                            freq_nxt  = tone(mem[0]);
`else
                            state_nxt = IDLE;
`endif
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
`ifdef NOTE_SEQUENCER_LOOP_EN
            // A second request stops a looping sequence immediately.
            if (play_edge && state_q != IDLE) begin
                state_nxt = IDLE;
                idx_nxt   = '0;
                timer_nxt = '0;
                freq_nxt  = '0;
            end
`endif
        end
    end

    always_comb begin
        playing      = (state_q != IDLE);
        full         = (count_q == CW'(DEPTH));
        note_counter = 4'(count_q);
    end

endmodule
